cpu_bus_serializer: RTL and testbench
=====================================

CPU_BUS_SERIALIZER -- requirements
Module: cpu_bus_serializer

Interface
REQ-001 The block SHALL have parameter ADDR_BYTES, default 4, giving the address bytes sent per transaction (legal range 1..4).
REQ-002 The block SHALL have parameter DATA_BYTES, default 4, giving the data bytes per transaction (legal range 1..4).
REQ-003 The block SHALL have parameter WAIT_MAX, default 15, giving the read wait-state limit in cycles (used only with TIMEOUT_EN).
REQ-004 The block SHALL have the following ports:
- clk  in  1  single clock; all state on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  CPU request present.
- req_ready  out  1  block can accept a request.
- req_write  in  1  1=write, 0=read.
- req_addr  in  8*ADDR_BYTES  request address.
- req_wdata  in  8*DATA_BYTES  write data.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  8*DATA_BYTES  read data.
- rsp_err  out  1  read timed out.
- bus_out  out  8  address/command byte lane.
- bus_sync  out  1  high on the first address byte of a transaction.
- bus_dq_out  out  8  write data byte.
- bus_dq_in  in  8  read data byte.
- bus_dq_oe  out  8  dq drive enable, all-ones or all-zeros.
- bus_ack  in  1  external device has read data ready.

Function
REQ-005 All outputs SHALL be registered.
REQ-006 The FSM SHALL have the states IDLE, ADDR, CMD, WDATA, WAIT, RDATA and RESP, with a byte index idx.
REQ-007 In IDLE, req_ready SHALL be 1; in all other states it SHALL be 0.
REQ-008 A request SHALL be accepted on a rising edge where req_valid and req_ready are both 1; at acceptance the block SHALL latch addr, wdata and write, and set idx=0.
REQ-009 In ADDR, the block SHALL drive bus_out = addr byte idx, LSB first, with bus_dq_oe=0; bus_sync SHALL be 1 only when idx=0; ADDR SHALL last ADDR_BYTES cycles.
REQ-010 CMD SHALL last 1 cycle with bus_out = {7'b0, write}.
REQ-011 After CMD, a write SHALL go to WDATA and a read SHALL go to WAIT.
REQ-012 WDATA SHALL last DATA_BYTES cycles: bus_dq_oe=8'hFF, bus_dq_out = wdata byte idx (LSB first), bus_out=0; it SHALL then go to RESP.
REQ-013 WAIT SHALL hold bus_dq_oe=0 and bus_out=0, and SHALL sample bus_ack each cycle (minimum 1 cycle); when bus_ack=1 it SHALL go to RDATA.
REQ-014 RDATA SHALL last DATA_BYTES cycles, capturing bus_dq_in into rdata byte idx, LSB first; it SHALL then go to RESP.
REQ-015 RESP SHALL last 1 cycle: rsp_valid=1, with rsp_rdata and rsp_err valid; it SHALL then go to IDLE, with no backpressure.
REQ-016 Write latency SHALL be: rsp_valid high in cycle ADDR_BYTES+DATA_BYTES+2 after acceptance (10 at defaults).
REQ-017 Read latency SHALL be ADDR_BYTES+DATA_BYTES+2+W cycles, where W = WAIT cycles (>=1).
REQ-018 rsp_rdata SHALL hold its value until the next read's RESP.
REQ-019 For a write, rsp_rdata SHALL be unchanged and rsp_err=0.
REQ-020 bus_ack SHALL be ignored outside WAIT; req_valid SHALL be ignored outside IDLE.
REQ-021 idx SHALL reset to 0 on every state change and SHALL never exceed its phase length minus 1.

Reset
REQ-022 While rst_n=0, asynchronously: state=IDLE, idx=0, req_ready=1, rsp_valid=0, rsp_err=0, rsp_rdata=0, bus_out=0, bus_sync=0, bus_dq_out=0, bus_dq_oe=0.
REQ-023 Reset asserted mid-transaction SHALL abort it with no rsp_valid pulse; the first post-reset request SHALL behave as from cold.

Configuration
REQ-024 With TIMEOUT_EN defined: if WAIT has lasted WAIT_MAX cycles without bus_ack, the block SHALL go to RESP with rsp_err=1 and rsp_rdata=0, skipping RDATA.
REQ-025 Without TIMEOUT_EN: WAIT SHALL persist indefinitely, rsp_err SHALL be constant 0, and WAIT_MAX SHALL be unused.

Verification
REQ-026 Write at defaults, addr=32'h12345678, wdata=32'hCAFEF00D: bus_out shall be 78,56,34,12 (sync on 78), then 01; dq shall be 0D,F0,FE,CA with oe=FF; rsp_valid shall be at cycle 10, rsp_err=0.
REQ-027 Read at defaults, addr=32'h00000010, bus_ack high 3 cycles after WAIT entry, dq_in 11,22,33,44: rsp_rdata shall be 32'h44332211, rsp_valid at cycle 14.
REQ-028 ADDR_BYTES=2, DATA_BYTES=1 write addr=16'hBEEF, wdata=8'h5A: bus_out shall be EF,BE,00-cmd 01; dq shall be 5A; rsp_valid shall be at cycle 5.
REQ-029 TIMEOUT_EN, WAIT_MAX=15, bus_ack held 0: rsp_valid with rsp_err=1 and rdata=0 after 15 WAIT cycles; the next read with ack shall complete normally with rsp_err=0.
REQ-030 Pull rst_n low during WDATA byte 2: outputs shall immediately take reset values with no rsp_valid; a back-to-back request after release shall be accepted on the first edge.
REQ-031 req_valid held high continuously: requests shall be accepted only in IDLE, one per transaction, with rsp_valid pulses never overlapping.

Source files
------------

// File: rtl/cpu_bus_serializer.sv
// CPU request serializer: address bytes, command byte, then write data or wait/read data, then a response pulse.
// Optional feature: define TIMEOUT_EN to end a read with rsp_err after WAIT_MAX wait cycles without bus_ack.
module cpu_bus_serializer #(
  parameter int ADDR_BYTES = 4,
  parameter int DATA_BYTES = 4,
  parameter int WAIT_MAX   = 15
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [8*ADDR_BYTES-1:0] req_addr,
  input  logic [8*DATA_BYTES-1:0] req_wdata,
  output logic                    rsp_valid,
  output logic [8*DATA_BYTES-1:0] rsp_rdata,
  output logic                    rsp_err,
  output logic [7:0]              bus_out,
  output logic                    bus_sync,
  output logic [7:0]              bus_dq_out,
  input  logic [7:0]              bus_dq_in,
  output logic [7:0]              bus_dq_oe,
  input  logic                    bus_ack
);

  typedef enum logic [2:0] {IDLE, ADDR, CMD, WDATA, WAIT, RDATA, RESP} state_e;

  localparam logic [1:0] A_LAST = 2'(ADDR_BYTES - 1);
  localparam logic [1:0] D_LAST = 2'(DATA_BYTES - 1);

  state_e                  state_q;
  logic [1:0]              idx_q;
  logic [8*ADDR_BYTES-1:0] addr_q;
  logic [8*DATA_BYTES-1:0] wdata_q, rdata_q, rsp_rdata_q;
  logic                    write_q, req_ready_q, rsp_valid_q, bus_sync_q;
  logic [7:0]              bus_out_q, dq_out_q, dq_oe_q;

  logic [1:0]              idx_inc;
  logic [7:0]              addr_nb, wdata_nb;
  logic [8*DATA_BYTES-1:0] rdata_d;

`ifdef TIMEOUT_EN
  localparam int WC_W = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX);
  logic [WC_W-1:0] wcnt_q;
  logic            rsp_err_q;
  assign rsp_err = rsp_err_q;
`else
  assign rsp_err = 1'b0;
`endif

  // Outputs are registered, so each transition loads the values for the byte about to go out.
  always_comb begin
    idx_inc  = idx_q + 2'd1;
    addr_nb  = 8'(addr_q >> {idx_inc, 3'b000});
    wdata_nb = 8'(wdata_q >> {idx_inc, 3'b000});
    rdata_d  = rdata_q;
    for (int b = 0; b < DATA_BYTES; b++)
      if (idx_q == 2'(b)) rdata_d[8*b +: 8] = bus_dq_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      write_q     <= 1'b0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      bus_out_q   <= '0;
      bus_sync_q  <= 1'b0;
      dq_out_q    <= '0;
      dq_oe_q     <= '0;
`ifdef TIMEOUT_EN
      wcnt_q      <= '0;
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      rsp_valid_q <= 1'b0;
      bus_sync_q  <= 1'b0;
      case (state_q)
        IDLE: if (req_valid && req_ready_q) begin
          addr_q      <= req_addr;
          wdata_q     <= req_wdata;
          write_q     <= req_write;
          idx_q       <= '0;
          state_q     <= ADDR;
          req_ready_q <= 1'b0;
          bus_out_q   <= req_addr[7:0];
          bus_sync_q  <= 1'b1;
        end
        ADDR: if (idx_q == A_LAST) begin
          state_q   <= CMD;
          idx_q     <= '0;
          bus_out_q <= {7'b0, write_q};
        end else begin
          idx_q     <= idx_inc;
          bus_out_q <= addr_nb;
        end
        CMD: begin
          idx_q     <= '0;
          bus_out_q <= '0;
          if (write_q) begin
            state_q  <= WDATA;
            dq_oe_q  <= 8'hFF;
            dq_out_q <= wdata_q[7:0];
          end else begin
            state_q  <= WAIT;
`ifdef TIMEOUT_EN
            wcnt_q   <= '0;
`endif
          end
        end
        WDATA: if (idx_q == D_LAST) begin
          state_q     <= RESP;
          idx_q       <= '0;
          dq_oe_q     <= '0;
          dq_out_q    <= '0;
          rsp_valid_q <= 1'b1;
`ifdef TIMEOUT_EN
          rsp_err_q   <= 1'b0;
`endif
        end else begin
          idx_q    <= idx_inc;
          dq_out_q <= wdata_nb;
        end
        WAIT: if (bus_ack) begin
          state_q <= RDATA;
          idx_q   <= '0;
        end
`ifdef TIMEOUT_EN
        else if (wcnt_q == WC_W'(WAIT_MAX - 1)) begin
          state_q     <= RESP;
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= 1'b1;
          rsp_rdata_q <= '0;
        end else begin
          wcnt_q <= wcnt_q + 1'b1;
        end
`endif
        RDATA: begin
          rdata_q <= rdata_d;
          if (idx_q == D_LAST) begin
            state_q     <= RESP;
            idx_q       <= '0;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= rdata_d;
`ifdef TIMEOUT_EN
            rsp_err_q   <= 1'b0;
`endif
          end else begin
            idx_q <= idx_inc;
          end
        end
        RESP: begin
          state_q     <= IDLE;
          idx_q       <= '0;
          req_ready_q <= 1'b1;
        end
        default: begin
          state_q     <= IDLE;
          idx_q       <= '0;
          req_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign bus_out    = bus_out_q;
  assign bus_sync   = bus_sync_q;
  assign bus_dq_out = dq_out_q;
  assign bus_dq_oe  = dq_oe_q;

endmodule

// File: tb/tb_cpu_bus_serializer.sv
// Bench for cpu_bus_serializer: randomized transactions against a cycle-position model of the bus protocol,
// plus a narrow (2 address / 1 data byte) instance and mid-transaction reset.
module tb_cpu_bus_serializer;
  localparam int A  = 4;
  localparam int D  = 4;
  localparam int WM = 15;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          req_valid, req_ready, req_write, rsp_valid, rsp_err, bus_sync, bus_ack;
  logic [31:0]   req_addr, req_wdata, rsp_rdata;
  logic [7:0]    bus_out, bus_dq_out, bus_dq_in, bus_dq_oe;

  logic          r2_valid, r2_ready, r2_write, r2_rsp_valid, r2_err, b2_sync, b2_ack;
  logic [15:0]   r2_addr;
  logic [7:0]    r2_wdata, r2_rdata, b2_out, b2_dq_out, b2_dq_in, b2_dq_oe;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] model_rdata;

  cpu_bus_serializer #(.ADDR_BYTES(A), .DATA_BYTES(D), .WAIT_MAX(WM)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .bus_out(bus_out), .bus_sync(bus_sync), .bus_dq_out(bus_dq_out),
    .bus_dq_in(bus_dq_in), .bus_dq_oe(bus_dq_oe), .bus_ack(bus_ack));

  cpu_bus_serializer #(.ADDR_BYTES(2), .DATA_BYTES(1), .WAIT_MAX(WM)) dut2 (
    .clk(clk), .rst_n(rst_n), .req_valid(r2_valid), .req_ready(r2_ready), .req_write(r2_write),
    .req_addr(r2_addr), .req_wdata(r2_wdata), .rsp_valid(r2_rsp_valid), .rsp_rdata(r2_rdata),
    .rsp_err(r2_err), .bus_out(b2_out), .bus_sync(b2_sync), .bus_dq_out(b2_dq_out),
    .bus_dq_in(b2_dq_in), .bus_dq_oe(b2_dq_oe), .bus_ack(b2_ack));

  // Called at a negedge in IDLE. w = wait cycles before ack; w <= 0 on a read means ack never comes.
  task automatic run_txn(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input int w, input logic [31:0] rb);
    int          L, ws;
    bit          tmo;
    logic [31:0] exp_rd;
    logic [16:0] exp_bus;
    tmo    = !wr && (w <= 0);
    ws     = tmo ? WM : w;
    L      = wr ? A + D + 2 : (tmo ? A + 2 + WM : A + D + 2 + w);
    exp_rd = wr ? model_rdata : (tmo ? 32'h0 : rb);
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL ready_at_issue got %b exp 1", req_ready); end
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata;
    bus_ack = 1'($urandom); bus_dq_in = 8'($urandom);
    for (int c = 1; c <= L + 1; c++) begin
      @(negedge clk);
      if (c == L + 1) begin
        checks++;
        if ({req_ready, rsp_valid} !== 2'b10) begin
          errors++; $display("FAIL idle_after_resp got ready/valid %b exp 10", {req_ready, rsp_valid});
        end
        req_valid = 1'b0;
      end else begin
        exp_bus[16:9] = (c <= A) ? 8'(addr >> (8 * (c - 1))) : (c == A + 1) ? {7'b0, wr} : 8'h00;
        exp_bus[8]    = (c == 1);
        exp_bus[7:0]  = (wr && c >= A + 2 && c <= A + 1 + D) ? 8'hFF : 8'h00;
        checks++;
        if ({bus_out, bus_sync, bus_dq_oe} !== exp_bus) begin
          errors++; $display("FAIL bus c=%0d got %h exp %h", c, {bus_out, bus_sync, bus_dq_oe}, exp_bus);
        end
        if (exp_bus[7:0] == 8'hFF) begin
          checks++;
          if (bus_dq_out !== 8'(wdata >> (8 * (c - A - 2)))) begin
            errors++; $display("FAIL dq_out c=%0d got %h exp %h", c, bus_dq_out, 8'(wdata >> (8 * (c - A - 2))));
          end
        end
        checks++;
        if ({req_ready, rsp_valid} !== {1'b0, c == L}) begin
          errors++; $display("FAIL ready_valid c=%0d got %b exp %b", c, {req_ready, rsp_valid}, {1'b0, c == L});
        end
        checks++;
        if (rsp_rdata !== ((c == L) ? exp_rd : model_rdata)) begin
          errors++; $display("FAIL rdata c=%0d got %h exp %h", c, rsp_rdata, (c == L) ? exp_rd : model_rdata);
        end
        if (c == L) begin
          checks++;
          if (rsp_err !== tmo) begin errors++; $display("FAIL rsp_err got %b exp %b", rsp_err, tmo); end
        end
        // Noise on every input the block is supposed to ignore at this point.
        req_valid = 1'($urandom); req_write = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
        if (!wr && c >= A + 1 && c <= A + ws) bus_ack = 1'b0;
        else if (!wr && !tmo && c == A + 1 + ws) bus_ack = 1'b1;
        else bus_ack = 1'($urandom);
        if (!wr && !tmo && c >= A + 2 + w && c <= A + 1 + w + D) bus_dq_in = 8'(rb >> (8 * (c - A - 2 - w)));
        else bus_dq_in = 8'($urandom);
      end
    end
    model_rdata = exp_rd;
  endtask

  task automatic test_reset;
    checks++;
    if ({req_ready, rsp_valid, rsp_err, bus_sync} !== 4'b1000) begin
      errors++; $display("FAIL reset_ctrl got %b exp 1000", {req_ready, rsp_valid, rsp_err, bus_sync});
    end
    checks++;
    if ({rsp_rdata, bus_out, bus_dq_out, bus_dq_oe} !== 56'h0) begin
      errors++; $display("FAIL reset_data got %h exp 0", {rsp_rdata, bus_out, bus_dq_out, bus_dq_oe});
    end
  endtask

  task automatic test_directed;
    run_txn(1'b1, 32'h12345678, 32'hCAFEF00D, 0, 32'h0);
    run_txn(1'b0, 32'h00000010, 32'h0, 4, 32'h44332211);
  endtask

  task automatic test_random;
    for (int i = 0; i < 24; i++)
      run_txn(1'($urandom), $urandom, $urandom, int'($urandom_range(1, 6)), $urandom);
  endtask

  task automatic test_small_cfg;
    logic [17:0] exp;
    checks++;
    if (r2_ready !== 1'b1) begin errors++; $display("FAIL small_ready got %b exp 1", r2_ready); end
    r2_valid = 1'b1; r2_write = 1'b1; r2_addr = 16'hBEEF; r2_wdata = 8'h5A;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      r2_valid = 1'b0;
      case (c)
        1: exp = {8'hEF, 1'b1, 8'h00, 1'b0};
        2: exp = {8'hBE, 1'b0, 8'h00, 1'b0};
        3: exp = {8'h01, 1'b0, 8'h00, 1'b0};
        4: exp = {8'h00, 1'b0, 8'hFF, 1'b0};
        5: exp = {8'h00, 1'b0, 8'h00, 1'b1};
        default: exp = 18'h0;
      endcase
      checks++;
      if ({b2_out, b2_sync, b2_dq_oe, r2_rsp_valid} !== exp) begin
        errors++; $display("FAIL small_bus c=%0d got %h exp %h", c, {b2_out, b2_sync, b2_dq_oe, r2_rsp_valid}, exp);
      end
      if (c == 4) begin
        checks++;
        if (b2_dq_out !== 8'h5A) begin errors++; $display("FAIL small_dq got %h exp 5a", b2_dq_out); end
      end
    end
    checks++;
    if ({r2_ready, r2_err} !== 2'b10) begin errors++; $display("FAIL small_end got %b exp 10", {r2_ready, r2_err}); end
  endtask

`ifdef TIMEOUT_EN
  task automatic test_timeout;
    run_txn(1'b0, $urandom, 32'h0, 0, 32'h0);
    run_txn(1'b0, $urandom, 32'h0, 2, $urandom);
  endtask
`endif

  task automatic test_reset_mid;
    req_valid = 1'b1; req_write = 1'b1; req_addr = $urandom; req_wdata = $urandom;
    for (int c = 1; c <= A + 3; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
    end
    checks++;
    if (bus_dq_oe !== 8'hFF) begin errors++; $display("FAIL mid_wdata_oe got %h exp ff", bus_dq_oe); end
    rst_n = 1'b0;
    #1;
    test_reset;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_no_rsp got %b exp 0", rsp_valid); end
    end
    rst_n = 1'b1;
    model_rdata = 32'h0;
    run_txn(1'b0, $urandom, $urandom, 3, $urandom);
    run_txn(1'b1, $urandom, $urandom, 0, 32'h0);
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; bus_dq_in = '0; bus_ack = 1'b0;
    r2_valid = 1'b0; r2_write = 1'b0; r2_addr = '0; r2_wdata = '0; b2_dq_in = '0; b2_ack = 1'b0;
    model_rdata = 32'h0;
    repeat (3) @(negedge clk);
    test_reset;
    rst_n = 1'b1;
    @(negedge clk);
    test_directed;
    test_random;
    test_small_cfg;
`ifdef TIMEOUT_EN
    test_timeout;
`endif
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
